// File: rtl/pc_pkg.sv
// pc_pkg: shared op-code constants for the PC/stack unit and its bench.
//   OP_HOLD..OP_RET : valid 3-bit operation codes; 110/111 are reserved.
package pc_pkg;
    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
//   clk, rst      : clock, synchronous active-high reset (clears pointer and depth)
//   push, pop     : push wdata / pop top entry (never both; pop only when not empty)
//   wdata, rdata  : entry to push / current top-of-stack entry
//   depth         : valid entry count; full/empty derived from it
module ras_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp, sp_inc, sp_dec;

    // sp is the next write slot; the top entry sits one slot below it, modulo DEPTH.
    always_comb begin
        sp_inc = (sp == PW'(DEPTH-1)) ? '0 : sp + 1'b1;
        sp_dec = (sp == '0) ? PW'(DEPTH-1) : sp - 1'b1;
        full   = depth == DW'(DEPTH);
        empty  = depth == '0;
        rdata  = mem[sp_dec];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            depth <= '0;
        end else if (push) begin
            sp    <= sp_inc;
            depth <= full ? depth : depth + 1'b1;
        end else if (pop) begin
            sp    <= sp_dec;
            depth <= depth - 1'b1;
        end
    end

    // Contents need no reset: they are only observable after a push.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[sp] <= wdata;
    end
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: registered program counter with hold/inc/load/branch/call/ret and a return-address stack.
//   clk, rst            : clock, synchronous active-high reset
//   en, op              : execute op when en=1, otherwise stall
//   target, offset      : absolute destination (LOAD/CALL), signed displacement (BRANCH)
//   pc, depth           : program counter, stack entry count
//   ras_empty, ras_full : stack status
//   ovf, unf, bad_op    : one-cycle error pulses (full CALL, empty RET, reserved op)
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int unsigned      STEP      = 1,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           target,
    input  logic [WIDTH-1:0]           offset,
    output logic [WIDTH-1:0]           pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ovf,
    output logic                       unf,
    output logic                       bad_op
);
    logic [WIDTH-1:0] seq_pc, ret_addr, pc_next;
    logic             is_call, is_ret, is_bad, push, pop;

    always_comb begin
        seq_pc  = pc + WIDTH'(STEP);
        is_call = en && op == OP_CALL;
        is_ret  = en && op == OP_RET;
        is_bad  = en && op[2:1] == 2'b11;
        push    = is_call && !rst;
        pop     = is_ret && !ras_empty && !rst;
        // Two's-complement add handles negative offsets; wrap is silent.
        pc_next = !en               ? pc :
                  op == OP_INC      ? seq_pc :
                  op == OP_LOAD     ? target :
                  op == OP_BRANCH   ? pc + offset :
                  op == OP_CALL     ? target :
                  op == OP_RET      ? (ras_empty ? seq_pc : ret_addr) :
                                      pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_VAL;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            bad_op <= 1'b0;
        end else begin
            pc     <= pc_next;
            ovf    <= is_call && ras_full;
            unf    <= is_ret && ras_empty;
            bad_op <= is_bad;
        end
    end

    ras_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (seq_pc),
        .rdata (ret_addr),
        .depth (depth),
        .full  (ras_full),
        .empty (ras_empty)
    );
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: scoreboard bench for pc_stack_unit against a queue-based reference model.
module tb_pc_stack_unit;
    import pc_pkg::*;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] depth;
        logic       empty, full, ovf, unf, bad;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] target = '0, offset = '0;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       ras_empty, ras_full, ovf, unf, bad_op;

    int compared = 0, mismatched = 0;
    exp_t       sb[$];
    logic [7:0] mstack[$];
    logic [7:0] mpc = 8'h00;

    always #5 clk = ~clk;

    pc_stack_unit #(.WIDTH(8), .STEP(1), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .offset(offset),
        .pc(pc), .depth(depth), .ras_empty(ras_empty), .ras_full(ras_full),
        .ovf(ovf), .unf(unf), .bad_op(bad_op)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] o,
                        input logic [7:0] t, input logic [7:0] f);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; op = o; target = t; offset = f;
        x.ovf = 1'b0; x.unf = 1'b0; x.bad = 1'b0;
        if (r) begin
            mpc = 8'h00;
            mstack.delete();
        end else if (e) begin
            case (o)
                OP_INC:    mpc = mpc + 8'd1;
                OP_LOAD:   mpc = t;
                OP_BRANCH: mpc = mpc + f;
                OP_CALL: begin
                    if (mstack.size() == 4) begin
                        void'(mstack.pop_front());
                        x.ovf = 1'b1;
                    end
                    mstack.push_back(mpc + 8'd1);
                    mpc = t;
                end
                OP_RET: begin
                    if (mstack.size() > 0) mpc = mstack.pop_back();
                    else begin
                        mpc = mpc + 8'd1;
                        x.unf = 1'b1;
                    end
                end
                3'b110, 3'b111: x.bad = 1'b1;
                default: ;
            endcase
        end
        x.pc    = mpc;
        x.depth = 3'(mstack.size());
        x.empty = mstack.size() == 0;
        x.full  = mstack.size() == 4;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("pc", 32'(pc), 32'(x.pc));
        check("depth", 32'(depth), 32'(x.depth));
        check("empty", 32'(ras_empty), 32'(x.empty));
        check("full", 32'(ras_full), 32'(x.full));
        check("ovf", 32'(ovf), 32'(x.ovf));
        check("unf", 32'(unf), 32'(x.unf));
        check("bad_op", 32'(bad_op), 32'(x.bad));
    endtask

    initial begin
        step(1, 0, OP_HOLD, 0, 0);
        check("reset_pc", 32'(pc), 32'h00);
        check("reset_empty", 32'(ras_empty), 32'd1);
        // Increment and silent wrap
        repeat (3) step(0, 1, OP_INC, 0, 0);
        check("inc3", 32'(pc), 32'h03);
        step(0, 1, OP_LOAD, 8'hFE, 0);
        step(0, 1, OP_INC, 0, 0);
        step(0, 1, OP_INC, 0, 0);
        check("inc_wrap", 32'(pc), 32'h00);
        // Backward and forward branch
        step(0, 1, OP_LOAD, 8'h10, 0);
        step(0, 1, OP_BRANCH, 0, 8'hF0);
        check("branch_back", 32'(pc), 32'h00);
        step(0, 1, OP_BRANCH, 0, 8'h05);
        check("branch_fwd", 32'(pc), 32'h05);
        // Nested call/return
        step(0, 1, OP_LOAD, 8'h20, 0);
        step(0, 1, OP_CALL, 8'h40, 0);
        step(0, 1, OP_CALL, 8'h60, 0);
        check("call2_depth", 32'(depth), 32'd2);
        step(0, 1, OP_RET, 0, 0);
        check("ret1", 32'(pc), 32'h41);
        step(0, 1, OP_RET, 0, 0);
        check("ret2", 32'(pc), 32'h21);
        // Overflow wrap, LIFO of the newest four, then underflow
        step(0, 1, OP_LOAD, 8'h00, 0);
        step(0, 1, OP_CALL, 8'h10, 0);
        step(0, 1, OP_CALL, 8'h20, 0);
        step(0, 1, OP_CALL, 8'h30, 0);
        step(0, 1, OP_CALL, 8'h40, 0);
        check("ovf_not_yet", 32'(ovf), 32'd0);
        step(0, 1, OP_CALL, 8'h50, 0);
        check("ovf_5th", 32'(ovf), 32'd1);
        step(0, 1, OP_RET, 0, 0);
        check("wret1", 32'(pc), 32'h41);
        step(0, 1, OP_RET, 0, 0);
        step(0, 1, OP_RET, 0, 0);
        step(0, 1, OP_RET, 0, 0);
        check("wret4", 32'(pc), 32'h11);
        step(0, 1, OP_RET, 0, 0);
        check("unf_pc", 32'(pc), 32'h12);
        check("unf", 32'(unf), 32'd1);
        // Stall and reserved op
        repeat (3) step(0, 0, OP_CALL, 8'h77, 0);
        check("stall_pc", 32'(pc), 32'h12);
        step(0, 1, 3'b111, 8'h77, 0);
        check("bad_op", 32'(bad_op), 32'd1);
        step(0, 1, 3'b110, 8'h77, 0);
        // Reset wins over an in-flight call
        step(0, 1, OP_CALL, 8'h10, 0);
        step(0, 1, OP_CALL, 8'h20, 0);
        step(1, 1, OP_CALL, 8'h30, 0);
        check("rst_call_pc", 32'(pc), 32'h00);
        check("rst_call_depth", 32'(depth), 32'd0);
        // Random mix
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0,
                 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the PC width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter STEP, default 1, giving the sequential increment (unsigned, < 2^WIDTH).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the return-address-stack entry count (legal range 2..16).
REQ-004 The block SHALL have parameter RESET_VAL, default 0, giving the PC value after reset.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit; 1 executes op, 0 stalls.
REQ-008 The block SHALL have port op, input, 3 bits, the operation code (see REQ-015).
REQ-009 The block SHALL have port target, input, WIDTH bits, the absolute destination for LOAD and CALL.
REQ-010 The block SHALL have port offset, input, WIDTH bits, the two's-complement displacement for BRANCH.
REQ-011 The block SHALL have port pc, output, WIDTH bits, the registered program counter.
REQ-012 The block SHALL have port depth, output, $clog2(DEPTH+1) bits, the count of valid stack entries.
REQ-013 The block SHALL have ports ras_empty and ras_full, each output, 1 bit, set when depth==0 and depth==DEPTH respectively.
REQ-014 The block SHALL have ports ovf, unf and bad_op, each output, 1 bit, registered single-cycle error pulses.

Function
REQ-015 Op encoding: 000 HOLD, 001 INC, 010 LOAD, 011 BRANCH, 100 CALL, 101 RET, 110/111 reserved.
REQ-016 Every op sampled at edge n SHALL be reflected on pc, depth and flags immediately after edge n (one-cycle latency, no combinational path from inputs to outputs).
REQ-017 HOLD: pc unchanged, stack unchanged.
REQ-018 INC: pc <= (pc + STEP) mod 2^WIDTH; wrap-around is silent, with no flag.
REQ-019 LOAD: pc <= target.
REQ-020 BRANCH: pc <= (pc + offset) mod 2^WIDTH, with offset sign-interpreted; forward and backward wrap are silent.
REQ-021 CALL, not full: push (pc + STEP) mod 2^WIDTH, depth += 1, pc <= target.
REQ-022 CALL, full: the stack operates circularly; the oldest entry is overwritten, depth stays DEPTH, pc <= target, and ovf pulses 1 for one cycle.
REQ-023 RET, not empty: pc <= the most recently pushed entry (pop), depth -= 1.
REQ-024 RET, empty: pc <= (pc + STEP) mod 2^WIDTH, depth stays 0, and unf pulses 1 for one cycle.
REQ-025 Reserved op: treated as HOLD, and bad_op pulses 1 for one cycle.
REQ-026 en=0: pc, stack, depth all held; ovf/unf/bad_op driven 0 regardless of op.
REQ-027 Error pulses SHALL be 0 in every cycle not caused by their own event; they are not sticky.
REQ-028 After any full-wrap sequence, the stack SHALL return the DEPTH most recent pushes in LIFO order.

Reset
REQ-029 rst=1 at a rising edge SHALL force pc=RESET_VAL, depth=0, ras_empty=1, ras_full=0, ovf=unf=bad_op=0, and the stack pointer=0.
REQ-030 rst SHALL take priority over en and every op, including an op in progress mid-call-sequence; stack contents after reset are don't-care and never observable.

Structure
REQ-031 Op-code constants (OP_HOLD..OP_RET) SHALL live in the shared package pc_pkg, for use by the decoder and the bench.
REQ-032 The return-address stack SHALL be a sub-module ras_stack (parameters WIDTH, DEPTH; ports push, pop, wdata, rdata, depth, full, empty; circular overwrite on full push).
REQ-033 Stack storage SHALL be a register array; no memory macro.

Verification
REQ-034 Scenario: WIDTH=8, rst then INC x3 -> pc 0,1,2,3; LOAD 0xFE, INC, INC -> pc 0xFE, 0xFF, 0x00, with no flag.
REQ-035 Scenario: pc=0x10, BRANCH offset 0xF0 (-16) -> pc 0x00; then BRANCH 0x05 -> 0x05.
REQ-036 Scenario: pc=0x20, CALL 0x40, CALL 0x60, RET, RET -> pc 0x40, 0x60, 0x41, 0x21; depth 1, 2, 1, 0.
REQ-037 Scenario: DEPTH=4, CALL x5 from pc=0x00 with targets 0x10,0x20,0x30,0x40,0x50 -> ovf on the 5th only; RET x4 yields 0x41,0x31,0x21,0x11; a 5th RET gives unf=1 and pc=0x12.
REQ-038 Scenario: en=0 with op=CALL for 3 cycles -> pc and depth unchanged, ovf=0; op=111 with en=1 -> bad_op pulse, pc held.
REQ-039 Scenario: rst asserted in the cycle with op=CALL at depth 2 -> next pc=RESET_VAL, depth=0, ras_empty=1.
